// File: rtl/multicycle_control.sv
// Control FSM for the shared multicycle MIPS datapath: sequences fetch, decode,
// execute, memory and writeback, with a bounded wait on a variable-latency memory.
module multicycle_control #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode_i,
  input  logic       zero_i,
  input  logic       mem_ready_i,
  output logic       pc_write_o,
  output logic [1:0] pc_src_o,
  output logic       i_or_d_o,
  output logic       mem_read_o,
  output logic       mem_write_o,
  output logic       ir_write_o,
  output logic       reg_dst_o,
  output logic       mem_to_reg_o,
  output logic       reg_write_o,
  output logic       jal_ctl_o,
  output logic       logic_ext_o,
  output logic       alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [2:0] alu_op_o,
  output logic       instr_done_o,
  output logic       illegal_o,
  output logic       bus_err_o,
  output logic [3:0] state_o
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC_R   = 4'd6,
    S_EXEC_I   = 4'd7,
    S_ALU_WB   = 4'd8,
    S_BRANCH   = 4'd9,
    S_JUMP     = 4'd10
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // Count value seen on the MAX_WAIT-th not-ready cycle of a memory state.
  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  state_e     state_q, state_d;
  logic [7:0] wait_q, wait_d;
  logic       bus_err_q, bus_err_d;
  logic       mem_state, timeout;

  logic       pc_write, i_or_d, mem_read, mem_write, ir_write, reg_dst;
  logic       mem_to_reg, reg_write, jal_ctl, logic_ext, alu_src_a;
  logic       instr_done, illegal;
  logic [1:0] pc_src, alu_src_b;
  logic [2:0] alu_op;

  always_comb begin
    mem_state = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
    timeout   = mem_state && !mem_ready_i && (wait_q == WAIT_LAST);
  end

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path leaves one
    // unassigned and no latch is inferred.
    state_d    = state_q;
    pc_write   = 1'b0;
    pc_src     = 2'b00;
    i_or_d     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    jal_ctl    = 1'b0;
    logic_ext  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 3'b000;
    instr_done = 1'b0;
    illegal    = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        alu_op    = 3'b011;
        ir_write  = mem_ready_i;
        pc_write  = mem_ready_i;
        if (mem_ready_i) state_d = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        alu_op    = 3'b011;
        case (opcode_i)
          OP_RTYPE:                         state_d = S_EXEC_R;
          OP_ADDI, OP_ORI, OP_ANDI, OP_LUI: state_d = S_EXEC_I;
          OP_LW, OP_SW:                     state_d = S_MEM_ADDR;
          OP_BEQ, OP_BNE:                   state_d = S_BRANCH;
          OP_J, OP_JAL:                     state_d = S_JUMP;
          default: begin
            illegal = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = 3'b011;
        state_d   = (opcode_i == OP_SW) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (mem_ready_i) state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        if (mem_ready_i) begin
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end
      end
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = 3'b111;
        state_d   = S_ALU_WB;
      end
      S_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        case (opcode_i)
          OP_ADDI: alu_op = 3'b100;
          OP_ORI: begin
            alu_op    = 3'b101;
            logic_ext = 1'b1;
          end
          OP_ANDI: begin
            alu_op    = 3'b001;
            logic_ext = 1'b1;
          end
          OP_LUI:  alu_op = 3'b110;
          default: alu_op = 3'b000;
        endcase
        state_d = S_ALU_WB;
      end
      S_ALU_WB: begin
        reg_write  = 1'b1;
        reg_dst    = (opcode_i == OP_RTYPE);
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a  = 1'b1;
        alu_op     = 3'b010;
        pc_src     = 2'b01;
        pc_write   = ((opcode_i == OP_BEQ) && zero_i) || ((opcode_i == OP_BNE) && !zero_i);
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_JUMP: begin
        pc_write   = 1'b1;
        pc_src     = 2'b10;
        instr_done = 1'b1;
        jal_ctl    = (opcode_i == OP_JAL);
        reg_write  = (opcode_i == OP_JAL);
        state_d    = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    // A timed-out access is abandoned: no write may escape in that cycle.
    if (timeout) begin
      state_d   = S_FETCH;
      mem_write = 1'b0;
      ir_write  = 1'b0;
      pc_write  = 1'b0;
      reg_write = 1'b0;
    end
  end

  always_comb begin
    bus_err_d = bus_err_q | timeout;
    if ((state_d != state_q) || timeout) begin
      wait_d = 8'd0;
    end else if (mem_state && !mem_ready_i) begin
      wait_d = wait_q + 8'd1;
    end else begin
      wait_d = wait_q;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      wait_q    <= 8'd0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign pc_write_o   = !reset && pc_write;
  assign pc_src_o     = reset ? 2'b00 : pc_src;
  assign i_or_d_o     = !reset && i_or_d;
  assign mem_read_o   = !reset && mem_read;
  assign mem_write_o  = !reset && mem_write;
  assign ir_write_o   = !reset && ir_write;
  assign reg_dst_o    = !reset && reg_dst;
  assign mem_to_reg_o = !reset && mem_to_reg;
  assign reg_write_o  = !reset && reg_write;
  assign jal_ctl_o    = !reset && jal_ctl;
  assign logic_ext_o  = !reset && logic_ext;
  assign alu_src_a_o  = !reset && alu_src_a;
  assign alu_src_b_o  = reset ? 2'b00 : alu_src_b;
  assign alu_op_o     = reset ? 3'b000 : alu_op;
  assign instr_done_o = !reset && instr_done;
  assign illegal_o    = !reset && illegal;
  assign bus_err_o    = !reset && (bus_err_q || timeout);
  assign state_o      = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized scoreboard bench for multicycle_control: a driver walks each instruction
// through its expected phase plan and queues per-cycle control words; a monitor compares.
module tb_multicycle_control;

  localparam int MAX_WAIT = 4;

  typedef struct packed {
    logic       pc_write;
    logic [1:0] pc_src;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       jal_ctl;
    logic       logic_ext;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       instr_done;
    logic       illegal;
    logic       bus_err;
    logic [3:0] state;
  } ctl_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode_i = 6'h00;
  logic       zero_i = 1'b0;
  logic       mem_ready_i = 1'b0;
  logic       pc_write_o, i_or_d_o, mem_read_o, mem_write_o, ir_write_o, reg_dst_o;
  logic       mem_to_reg_o, reg_write_o, jal_ctl_o, logic_ext_o, alu_src_a_o;
  logic       instr_done_o, illegal_o, bus_err_o;
  logic [1:0] pc_src_o, alu_src_b_o;
  logic [2:0] alu_op_o;
  logic [3:0] state_o;

  ctl_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  bit   sticky_err = 1'b0;

  multicycle_control #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset(reset), .opcode_i(opcode_i), .zero_i(zero_i),
    .mem_ready_i(mem_ready_i), .pc_write_o(pc_write_o), .pc_src_o(pc_src_o),
    .i_or_d_o(i_or_d_o), .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
    .ir_write_o(ir_write_o), .reg_dst_o(reg_dst_o), .mem_to_reg_o(mem_to_reg_o),
    .reg_write_o(reg_write_o), .jal_ctl_o(jal_ctl_o), .logic_ext_o(logic_ext_o),
    .alu_src_a_o(alu_src_a_o), .alu_src_b_o(alu_src_b_o), .alu_op_o(alu_op_o),
    .instr_done_o(instr_done_o), .illegal_o(illegal_o), .bus_err_o(bus_err_o),
    .state_o(state_o)
  );

  always #5 clk = ~clk;

  function automatic bit is_legal(input logic [5:0] op);
    return op inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h0C, 6'h0D,
                      6'h0F, 6'h23, 6'h2B};
  endfunction

  // Expected control word for one phase of an instruction, straight from the
  // per-phase signal list; anything not named stays 0.
  function automatic ctl_t phase_word(input int ph, input logic [5:0] op,
                                      input logic rdy, input logic z, input bit tmo);
    ctl_t c = '0;
    c.state = 4'(ph);
    case (ph)
      0: begin
        c.mem_read = 1; c.alu_src_b = 2'b01; c.alu_op = 3'b011;
        c.ir_write = rdy; c.pc_write = rdy;
      end
      1: begin
        c.alu_src_b = 2'b11; c.alu_op = 3'b011; c.illegal = !is_legal(op);
      end
      2: begin c.alu_src_a = 1; c.alu_src_b = 2'b10; c.alu_op = 3'b011; end
      3: begin c.mem_read = 1; c.i_or_d = 1; end
      4: begin c.reg_write = 1; c.mem_to_reg = 1; c.instr_done = 1; end
      5: begin c.mem_write = !tmo; c.i_or_d = 1; c.instr_done = rdy; end
      6: begin c.alu_src_a = 1; c.alu_op = 3'b111; end
      7: begin
        c.alu_src_a = 1; c.alu_src_b = 2'b10;
        c.alu_op    = (op == 6'h08) ? 3'b100 : (op == 6'h0D) ? 3'b101 :
                      (op == 6'h0C) ? 3'b001 : 3'b110;
        c.logic_ext = (op == 6'h0D) || (op == 6'h0C);
      end
      8: begin c.reg_write = 1; c.reg_dst = (op == 6'h00); c.instr_done = 1; end
      9: begin
        c.alu_src_a = 1; c.alu_op = 3'b010; c.pc_src = 2'b01; c.instr_done = 1;
        c.pc_write  = (op == 6'h04) ? z : !z;
      end
      10: begin
        c.pc_write = 1; c.pc_src = 2'b10; c.instr_done = 1;
        c.jal_ctl = (op == 6'h03); c.reg_write = (op == 6'h03);
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  task automatic drive(input logic rst, input logic rdy, input logic z,
                       input logic [5:0] op, input bit chk, input ctl_t e);
    @(posedge clk);
    #1;
    reset       = rst;
    mem_ready_i = rdy;
    zero_i      = z;
    opcode_i    = op;
    if (chk) exp_q.push_back(e);
  endtask

  // fd/md: not-ready cycles before the fetch / data access completes.
  // abort_at: cycle index (from FETCH) at which reset is pulsed, -1 for none.
  task automatic run_instr(input logic [5:0] op, input int fd, input int md,
                           input logic z, input int abort_at);
    int   plan[$];
    int   n = 0;
    ctl_t e;
    plan = {0, 1};
    case (op)
      6'h00:                      plan = {plan, 6, 8};
      6'h08, 6'h0C, 6'h0D, 6'h0F: plan = {plan, 7, 8};
      6'h23:                      plan = {plan, 2, 3, 4};
      6'h2B:                      plan = {plan, 2, 5};
      6'h04, 6'h05:               plan = {plan, 9};
      6'h02, 6'h03:               plan = {plan, 10};
      default: ;
    endcase
    foreach (plan[i]) begin
      int ph    = plan[i];
      bit is_mem = (ph == 0) || (ph == 3) || (ph == 5);
      int waits = (ph == 0) ? fd : (is_mem ? md : 0);
      for (int k = 0; k <= MAX_WAIT; k++) begin
        logic rdy = is_mem ? logic'(k >= waits) : logic'($urandom_range(0, 1));
        bit   tmo = is_mem && !rdy && (k == MAX_WAIT - 1);
        if (n == abort_at) begin
          e = '0;
          e.state = 4'(ph);
          drive(1'b1, rdy, z, op, 1'b1, e);
          sticky_err = 1'b0;
          return;
        end
        e = phase_word(ph, op, rdy, z, tmo);
        e.bus_err = sticky_err || tmo;
        drive(1'b0, rdy, z, op, 1'b1, e);
        n++;
        if (tmo) begin
          sticky_err = 1'b1;
          return;
        end
        if (!is_mem || rdy) break;
      end
    end
  endtask

  initial begin : monitor
    ctl_t a, e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {pc_write_o, pc_src_o, i_or_d_o, mem_read_o, mem_write_o, ir_write_o,
             reg_dst_o, mem_to_reg_o, reg_write_o, jal_ctl_o, logic_ext_o,
             alu_src_a_o, alu_src_b_o, alu_op_o, instr_done_o, illegal_o,
             bus_err_o, state_o};
        total++;
        if (a !== e || (mem_read_o && mem_write_o)) begin
          bad++;
          $display("FAIL ctl_word t=%0t state=%0d got=%h want=%h", $time, e.state, a, e);
        end
      end
    end
  end

  logic [5:0] legal_ops [11] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08,
                                 6'h0C, 6'h0D, 6'h0F, 6'h23, 6'h2B};

  initial begin : stimulus
    ctl_t zero_word = '0;
    // Reset held for three cycles; from the first edge the state is FETCH.
    repeat (3) drive(1'b1, 1'b1, 1'b0, 6'h00, 1'b1, zero_word);

    run_instr(6'h00, 0, 0, 1'b0, -1);   // ADD
    run_instr(6'h23, 0, 2, 1'b0, -1);   // LW with two data wait cycles
    run_instr(6'h04, 0, 0, 1'b1, -1);   // BEQ taken
    run_instr(6'h05, 0, 0, 1'b1, -1);   // BNE not taken
    run_instr(6'h03, 0, 0, 1'b0, -1);   // JAL
    run_instr(6'h3F, 0, 0, 1'b0, -1);   // illegal
    run_instr(6'h2B, 1, 1, 1'b0, -1);   // SW
    run_instr(6'h0D, 0, 0, 1'b0, -1);   // ORI
    run_instr(6'h0F, 2, 0, 1'b0, -1);   // LUI
    run_instr(6'h08, 0, 0, 1'b0, -1);   // ADDI
    run_instr(6'h0C, 0, 0, 1'b0, -1);   // ANDI
    run_instr(6'h02, 0, 0, 1'b0, -1);   // J
    run_instr(6'h23, 0, 3, 1'b0, -1);   // ready on the last permitted cycle
    run_instr(6'h00, 9, 0, 1'b0, -1);   // fetch timeout
    run_instr(6'h00, 0, 0, 1'b0, -1);   // sticky error stays visible
    run_instr(6'h2B, 0, 9, 1'b0, -1);   // write timeout
    run_instr(6'h23, 0, 0, 1'b0, 3);    // reset mid-LW clears the error
    run_instr(6'h00, 0, 0, 1'b0, -1);

    for (int i = 0; i < 300; i++) begin
      logic [5:0] op;
      int fd, md, ab;
      op = ($urandom_range(0, 15) == 0) ? 6'($urandom) : legal_ops[$urandom_range(0, 10)];
      fd = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 5) : 0;
      md = $urandom_range(0, 5);
      ab = ($urandom_range(0, 19) == 0) ? $urandom_range(0, 6) : -1;
      run_instr(op, fd, md, logic'($urandom_range(0, 1)), ab);
    end

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      bad++;
      $display("FAIL drain pending=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
